// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and helpers for the fetch PC unit.
package fetch_pc_unit_pkg;

   // Default PC / target width (word-addressed).
   localparam int unsigned DefaultAddrWidth = 16;

   // 2-bit saturating counter encodings.
   typedef logic [1:0] ctr_t;
   localparam ctr_t CtrSnt = 2'b00;
   localparam ctr_t CtrWnt = 2'b01;
   localparam ctr_t CtrWt  = 2'b10;
   localparam ctr_t CtrSt  = 2'b11;

   // Saturating step towards taken (+1) or not-taken (-1).
   function automatic ctr_t ctr_step(input ctr_t ctr, input logic taken);
      ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != CtrSt) res = ctr + 2'd1;
      end else begin
         if (ctr != CtrSnt) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_pht_counters.sv
// Pattern history table: 2^PHT_BITS two-bit saturating counters.
// One combinational read port for fetch, one synchronous update port for resolve.
module fetch_pc_unit_pht_counters
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned PHT_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PHT_BITS-1:0] rd_idx,
   output ctr_t                rd_ctr,
   input  logic                upd_en,
   input  logic [PHT_BITS-1:0] upd_idx,
   input  logic                upd_taken
);

   localparam int unsigned Entries = 2 ** PHT_BITS;

   ctr_t ctr_q [Entries];

   // Fetch sees the pre-update value when it hits the index being trained.
   always_comb begin
      rd_ctr = ctr_q[rd_idx];
   end

   // Reset all counters to weakly-not-taken; otherwise train the resolved entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < Entries; i++) begin
            ctr_q[i] <= CtrWnt;
         end
      end else if (upd_en) begin
         ctr_q[upd_idx] <= ctr_step(ctr_q[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC generator: PC register, next-PC selection from LUT hit plus
// PHT direction, mispredict redirect, and a registered LUT training write.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = DefaultAddrWidth,
   parameter int unsigned            PHT_BITS   = 4,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] lut_read_key,
   input  logic [ADDR_WIDTH-1:0] lut_read_val,
   input  logic                  lut_read_valid,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_target,
   input  logic                  br_resolve,
   input  logic [ADDR_WIDTH-1:0] br_pc,
   input  logic                  br_taken,
   input  logic [ADDR_WIDTH-1:0] br_target,
   input  logic                  br_pred_taken,
   input  logic [ADDR_WIDTH-1:0] br_pred_target,
   output logic                  flush,
   output logic                  lut_write,
   output logic [ADDR_WIDTH-1:0] lut_write_key,
   output logic [ADDR_WIDTH-1:0] lut_write_val
);

   localparam logic [ADDR_WIDTH-1:0] PcOne = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  lut_write_q;
   logic [ADDR_WIDTH-1:0] lut_write_key_q, lut_write_val_q;
   ctr_t                  fetch_ctr;
   logic                  mispredict;

   fetch_pc_unit_pht_counters #(
      .PHT_BITS (PHT_BITS)
   ) u_pht (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (pc_q[PHT_BITS-1:0]),
      .rd_ctr    (fetch_ctr),
      .upd_en    (br_resolve),
      .upd_idx   (br_pc[PHT_BITS-1:0]),
      .upd_taken (br_taken)
   );

   // Prediction, mispredict detection and next-PC selection.
   always_comb begin
      pred_taken  = lut_read_valid & fetch_ctr[1];
      pred_target = lut_read_val;
      // A taken branch whose target differs is a mispredict even if direction matched.
      mispredict  = br_resolve & ((br_taken != br_pred_taken) |
                                  (br_taken & (br_target != br_pred_target)));
      flush       = mispredict & ~reset;
      if (mispredict) begin
         pc_d = br_taken ? br_target : (br_pc + PcOne);
      end else if (stall) begin
         pc_d = pc_q;
      end else begin
         pc_d = pred_taken ? lut_read_val : (pc_q + PcOne);
      end
   end

   // PC register and one-cycle-delayed LUT training write.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q            <= RESET_PC;
         lut_write_q     <= 1'b0;
         lut_write_key_q <= '0;
         lut_write_val_q <= '0;
      end else begin
         pc_q        <= pc_d;
         lut_write_q <= br_resolve & br_taken;
         if (br_resolve & br_taken) begin
            lut_write_key_q <= br_pc;
            lut_write_val_q <= br_target;
         end
      end
   end

   assign pc            = pc_q;
   assign lut_read_key  = pc_q;
   assign lut_write     = lut_write_q;
   assign lut_write_key = lut_write_key_q;
   assign lut_write_val = lut_write_val_q;

endmodule
